// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - minuteCore instruction fetch: PC generation, imem handshake, PC/instr FIFO to decode
// Optional same-cycle bypass of the FIFO when FETCH_BYPASS_EN is defined.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_rd_addr,
    output logic               imem_rd_enable,
    input  logic [INSTR_W-1:0] imem_rd_data,
    input  logic               imem_rd_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  req_pc;
    logic [ADDR_W-1:0]  cur_addr;
    logic               inflight;
    logic               drop;
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_after_pop;
    logic               fifo_pop;
    logic               complete;
    logic               issue;
    logic               accept;
    logic               push;

    // A new request is only issued when a FIFO slot is guaranteed for its response;
    // a held (in-flight) request already owns its slot.
    always_comb begin
        fifo_pop        = (count != '0) && out_ready;
        count_after_pop = count - CNT_W'(fifo_pop);
        cur_addr        = inflight ? req_pc : fetch_pc;
        imem_rd_addr    = cur_addr;
        imem_rd_enable  = !reset && (inflight || (count_after_pop < CNT_W'(DEPTH)));
        complete        = imem_rd_enable && imem_rd_ready;
        issue           = imem_rd_enable && !inflight;
        accept          = complete && !drop && !redirect_valid;
    end

`ifdef FETCH_BYPASS_EN
    logic bypass;

    always_comb begin
        bypass    = accept && (count == '0) && out_ready;
        push      = accept && !bypass;
        out_valid = (count != '0) || bypass;
        out_instr = bypass ? imem_rd_data : instr_mem[rd_ptr];
        out_pc    = bypass ? cur_addr : pc_mem[rd_ptr];
    end
`else
    always_comb begin
        push      = accept;
        out_valid = (count != '0);
        out_instr = instr_mem[rd_ptr];
        out_pc    = pc_mem[rd_ptr];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            drop     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            if (issue) begin
                req_pc <= fetch_pc;
            end
            inflight <= imem_rd_enable && !imem_rd_ready;

            // A request still outstanding across a redirect edge must finish, but its data is stale.
            if (complete) begin
                drop <= 1'b0;
            end else if (redirect_valid && imem_rd_enable) begin
                drop <= 1'b1;
            end

            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~ADDR_W'(3);
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end

            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr]    <= cur_addr;
                    instr_mem[wr_ptr] <= imem_rd_data;
                    wr_ptr            <= wr_ptr + PTR_W'(1);
                end
                if (fifo_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(fifo_pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
// Memory model returns addr ^ 32'hC0DE0000 after a programmable number of wait cycles.
module tb_fetch_stage;
    logic        clk;
    logic        reset;
    logic [31:0] imem_rd_addr;
    logic        imem_rd_enable;
    logic [31:0] imem_rd_data;
    logic        imem_rd_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    int   total = 0;
    int   bad   = 0;
    int   lat;
    int   wcnt;
    logic force_ready;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_rd_addr   (imem_rd_addr),
        .imem_rd_enable (imem_rd_enable),
        .imem_rd_data   (imem_rd_data),
        .imem_rd_ready  (imem_rd_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rd_data  = imem_rd_addr ^ 32'hC0DE0000;
    assign imem_rd_ready = force_ready || (imem_rd_enable && (wcnt >= lat));

    always @(posedge clk or posedge reset) begin
        if (reset) wcnt <= 0;
        else if (imem_rd_enable && imem_rd_ready) wcnt <= 0;
        else if (imem_rd_enable) wcnt <= wcnt + 1;
    end

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'hC0DE0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [31:0] lat_addr  [9] = '{32'h10, 32'h10, 32'h14, 32'h14, 32'h14, 32'h18, 32'h18, 32'h18, 32'h1C};
    logic        lat_valid [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] lat_pc    [9] = '{32'h0, 32'h0, 32'h10, 32'h0, 32'h0, 32'h14, 32'h0, 32'h0, 32'h18};

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        out_ready = 1'b1; lat = 0; force_ready = 1'b0;
        tick(); tick();
        chk("rst_enable", {31'b0, imem_rd_enable}, 32'h0);
        chk("rst_addr", imem_rd_addr, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);

        reset = 1'b0;
        #1;
        chk("first_enable", {31'b0, imem_rd_enable}, 32'h1);
        chk("first_addr", imem_rd_addr, 32'h0);

        // zero-wait streaming
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("zw_addr", imem_rd_addr, 32'(4 * k));
            chk("zw_valid", {31'b0, out_valid}, 32'h1);
            chk("zw_pc", out_pc, 32'(4 * (k - 1)));
            chk("zw_instr", out_instr, ins(32'(4 * (k - 1))));
        end

        // 3-cycle memory latency
        lat = 2;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("lat_enable", {31'b0, imem_rd_enable}, 32'h1);
            chk("lat_addr", imem_rd_addr, lat_addr[k]);
            chk("lat_valid", {31'b0, out_valid}, {31'b0, lat_valid[k]});
            if (lat_valid[k]) chk("lat_pc", out_pc, lat_pc[k]);
        end

        // decode stall: FIFO fills to DEPTH, enable drops, stray ready ignored
        lat = 0; out_ready = 1'b0;
        tick();
        force_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("stall_enable", {31'b0, imem_rd_enable}, 32'h0);
            chk("stall_valid", {31'b0, out_valid}, 32'h1);
            chk("stall_pc", out_pc, 32'h18);
            tick();
        end
        force_ready = 1'b0; out_ready = 1'b1;
        #1;
        chk("release_enable", {31'b0, imem_rd_enable}, 32'h1);
        chk("release_addr", imem_rd_addr, 32'h20);
        chk("release_pc", out_pc, 32'h18);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("drain_pc", out_pc, 32'h18 + 32'(4 * k));
            chk("drain_instr", out_instr, ins(32'h18 + 32'(4 * k)));
            chk("drain_addr", imem_rd_addr, 32'h20 + 32'(4 * k));
        end

        // redirect while a request is in flight
        lat = 2;
        tick();
        chk("rd1_pc", out_pc, 32'h28);
        chk("rd1_addr", imem_rd_addr, 32'h2C);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rd2_held_addr", imem_rd_addr, 32'h2C);
        chk("rd2_enable", {31'b0, imem_rd_enable}, 32'h1);
        chk("rd2_valid", {31'b0, out_valid}, 32'h0);
        tick();
        chk("rd3_addr", imem_rd_addr, 32'h100);
        chk("rd3_valid", {31'b0, out_valid}, 32'h0);
        tick(); tick();
        chk("rd5_valid", {31'b0, out_valid}, 32'h0);
        tick();
        chk("rd6_valid", {31'b0, out_valid}, 32'h1);
        chk("rd6_pc", out_pc, 32'h100);
        chk("rd6_instr", out_instr, ins(32'h100));
        chk("rd6_addr", imem_rd_addr, 32'h104);

        // redirect coinciding with completion and pop, all slots reserved
        out_ready = 1'b0;
        tick();
        chk("co_addr", imem_rd_addr, 32'h104);
        chk("co_valid", {31'b0, out_valid}, 32'h1);
        tick();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        chk("co_ready", {31'b0, imem_rd_ready}, 32'h1);
        tick();
        redirect_valid = 1'b0; lat = 0;
        #1;
        chk("co_valid_after", {31'b0, out_valid}, 32'h0);
        chk("co_new_addr", imem_rd_addr, 32'h200);
        tick();
        chk("co_pc", out_pc, 32'h200);
        chk("co_addr_next", imem_rd_addr, 32'h204);

        // PC wrap at top of address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr", imem_rd_addr, 32'hFFFFFFFC);
        chk("wrap_valid0", {31'b0, out_valid}, 32'h0);
        tick();
        chk("wrap_next_addr", imem_rd_addr, 32'h0);
        chk("wrap_pc", out_pc, 32'hFFFFFFFC);

        // asynchronous reset during an outstanding request
        lat = 2; out_ready = 1'b0;
        tick();
        chk("mid_enable", {31'b0, imem_rd_enable}, 32'h1);
        chk("mid_valid", {31'b0, out_valid}, 32'h1);
        reset = 1'b1;
        #1;
        chk("arst_enable", {31'b0, imem_rd_enable}, 32'h0);
        chk("arst_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_pc", out_pc, 32'h0);
        force_ready = 1'b1;
        tick();
        chk("arst_ready_ignored", {31'b0, out_valid}, 32'h0);
        reset = 1'b0; force_ready = 1'b0; lat = 0; out_ready = 1'b1;
        #1;
        chk("post_enable", {31'b0, imem_rd_enable}, 32'h1);
        chk("post_addr", imem_rd_addr, 32'h0);
        tick();
        chk("post_valid", {31'b0, out_valid}, 32'h1);
        chk("post_pc", out_pc, 32'h0);
        chk("post_instr", out_instr, ins(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch front end of minuteCore: sits between the instruction memory port (imem_rd_*) and the decode stage. Generates sequential PCs, runs the single-outstanding-request handshake with instruction memory, buffers returned instructions with their PCs in a small FIFO, and hands them to decode over a valid/ready interface. A redirect input (branch/jump/exception) flushes the buffer and restarts fetch at a new PC, discarding any in-flight response.

## Interface

Parameters:
- ADDR_W, 32: byte-address width (imem_rd_addr, PCs).
- INSTR_W, 32: instruction width.
- RESET_PC, 0: first fetch address after reset.
- DEPTH, 2: FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_rd_addr  out  ADDR_W  fetch address; held stable while imem_rd_enable high and imem_rd_ready low.
- imem_rd_enable  out  1  read request.
- imem_rd_data  in  INSTR_W  instruction; valid only when imem_rd_ready high.
- imem_rd_ready  in  1  response strobe; completes the current request.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  restart address; bits [1:0] ignored (treated as 0).
- out_valid  out  1  FIFO head valid.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  head PC.
- out_ready  in  1  decode accepts head.

## Operation

- Registers: fetch_pc (next address to request), req_pc (address of in-flight request), inflight, drop, FIFO (pc, instr) with count.
- Request issue: imem_rd_enable=1 whenever (inflight && !ready-this-cycle) or (count + inflight − pop + push < DEPTH), i.e. never issue unless a FIFO slot is reserved. imem_rd_addr = req_pc while inflight, else fetch_pc.
- Request completes on a rising edge where imem_rd_enable && imem_rd_ready. imem_rd_ready with enable low is ignored.
- On completion, drop=0: push {req_pc, imem_rd_data}; fetch_pc advances by 4 at issue (mod 2^ADDR_W, 0xFFFFFFFC wraps to 0).
- Back-to-back: if completion and a new issue coincide, enable stays high and address changes to the next PC on that edge.
- Redirect (sampled at edge): FIFO flushed (count=0), fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}. If a request is in flight and not completing that edge, drop=1: enable and address stay held until ready; that response is discarded, then fetch resumes at new PC. Redirect wins over a same-edge completion (response discarded) and over a same-edge pop.
- Pop: out_valid && out_ready at edge removes head.
- FIFO full: no new issue; in-flight completion always has a reserved slot, so no overflow. Empty: out_valid=0, out_instr/out_pc hold last value (don't care).

## Timing

- Reset values: imem_rd_enable=0, imem_rd_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0; fetch_pc=RESET_PC, inflight=0, drop=0, count=0.
- First cycle after reset release: imem_rd_enable=1, addr=RESET_PC.
- Response-to-output latency: 1 cycle (registered FIFO) — out_valid rises the cycle after the completing edge.
- With zero-wait memory (ready same cycle as enable) and out_ready=1: one instruction per cycle sustained.
- Redirect-to-request: new PC on imem_rd_addr the cycle after redirect edge if nothing in flight; otherwise the cycle after the dropped response completes.
- Reset mid-request: enable drops immediately (asynchronous); a later imem_rd_ready is ignored.

## Configuration

- FETCH_BYPASS_EN: when defined, if the FIFO is empty and a non-dropped response completes while out_ready=1, the instruction is presented combinationally (out_valid=1, out_instr=imem_rd_data, out_pc=req_pc) in the same cycle and not pushed; latency 0. Not defined: all responses go through the FIFO, latency 1, no combinational path from imem_* to out_*.

## Test plan

- Reset, RESET_PC=0, zero-wait memory, out_ready=1 -> addresses 0x0,0x4,0x8… one per cycle; out_pc trails by 1 cycle with matching instructions.
- Memory with 3-cycle ready latency -> address held 3 cycles per request; out_valid pulses every 3 cycles, no duplicates or skips.
- out_ready=0 for 10 cycles -> exactly DEPTH (2) instructions buffered, enable low after, no loss; release -> PCs 0x0,0x4,0x8 in order.
- Redirect to 0x103 while request to 0x8 in flight -> 0x8 data discarded, FIFO empty, next request 0x100, out_pc next = 0x100.
- Redirect on same edge as completion and pop, FIFO full -> out_valid=0 next cycle, response dropped, fetch at redirect PC.
- fetch_pc 0xFFFFFFFC -> next request 0x00000000; reset asserted mid-request -> enable=0, out_valid=0 immediately.
